// File: rtl/mem_1rw_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency RAM among NREQ requesters.
// Zero-fills the RAM after reset, then serves one access per cycle with a registered response.
module mem_1rw_arbiter #(
  parameter int NREQ   = 2,
  parameter int DEPTH  = 48,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_wmode,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        resp_valid,
  output logic [NREQ-1:0]        resp_err,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   init_done,
  output logic [ADDR_W-1:0]      RW0_addr,
  output logic                   RW0_en,
  output logic                   RW0_clk,
  output logic                   RW0_wmode,
  output logic [DATA_W-1:0]      RW0_wdata,
  input  logic [DATA_W-1:0]      RW0_rdata
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [PTR_W-1:0]  r_ptr;
  logic [NREQ-1:0]   r_resp_valid;
  logic [NREQ-1:0]   r_resp_err;
  logic              r_resp_rd;

  logic              w_any;
  logic [PTR_W-1:0]  w_gnt;
  logic [PTR_W-1:0]  w_idx;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wmode;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;
  logic              w_accept;
  logic              w_init_last;

  // Rotating-priority search: first valid requester at or after the pointer.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_gnt_oh    = NREQ'(1) << w_gnt;
  assign w_addr      = req_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
  assign w_wmode     = req_wmode[w_gnt];
  assign w_wdata     = req_wdata[int'(w_gnt)*DATA_W +: DATA_W];
  assign w_in_range  = int'(w_addr) < DEPTH;
  assign w_init_last = int'(r_init_cnt) == DEPTH - 1;
  // Nothing is accepted in the reset cycle, so no request is silently lost.
  assign w_accept    = (r_state == ST_RUN) && w_any && !reset;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready = '0;
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = w_addr;
    RW0_wdata = w_wdata;
    case (r_state)
      ST_INIT: begin
        RW0_en    = !reset;
        RW0_wmode = 1'b1;
        RW0_addr  = r_init_cnt;
        RW0_wdata = '0;
      end
      ST_RUN: begin
        req_ready = w_accept ? w_gnt_oh : '0;
        RW0_en    = w_accept && w_in_range;
        RW0_wmode = w_wmode;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_init_cnt   <= '0;
      r_ptr        <= '0;
      r_resp_valid <= '0;
      r_resp_err   <= '0;
      r_resp_rd    <= 1'b0;
    end else begin
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_accept) r_ptr <= (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;
      r_resp_valid <= w_accept ? w_gnt_oh : '0;
      r_resp_err   <= (w_accept && !w_in_range) ? w_gnt_oh : '0;
      r_resp_rd    <= w_accept && w_in_range && !w_wmode;
    end
  end

  // A response already registered when reset arrives is suppressed, not delivered.
  assign resp_valid = r_resp_valid & {NREQ{!reset}};
  assign resp_err   = r_resp_err & {NREQ{!reset}};
  assign resp_rdata = (r_resp_rd && !reset) ? RW0_rdata : '0;
  assign init_done  = r_state == ST_RUN;
  assign RW0_clk    = clock;

endmodule

// File: tb/tb_mem_1rw_arbiter.sv
// Scoreboard bench for mem_1rw_arbiter: a reference model predicts grants and responses,
// a separate monitor compares each cycle's response outputs against the queued predictions.
module tb_mem_1rw_arbiter;

  localparam int NREQ   = 2;
  localparam int DEPTH  = 48;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ-1:0]        req_wmode = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_err;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   init_done;
  logic [ADDR_W-1:0]      RW0_addr;
  logic                   RW0_en;
  logic                   RW0_clk;
  logic                   RW0_wmode;
  logic [DATA_W-1:0]      RW0_wdata;
  logic [DATA_W-1:0]      RW0_rdata;

  mem_1rw_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wmode(req_wmode), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_clk(RW0_clk),
    .RW0_wmode(RW0_wmode), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural mem_1rw, preloaded with garbage so the zero-fill is observable.
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_rdata;
  initial begin
    foreach (ram[i]) ram[i] = {$urandom, $urandom};
    ram_rdata = {$urandom, $urandom};
  end
  always @(posedge RW0_clk) begin
    if (RW0_en && int'(RW0_addr) < DEPTH) begin
      if (RW0_wmode) ram[RW0_addr] <= RW0_wdata;
      else           ram_rdata     <= ram[RW0_addr];
    end
  end
  assign RW0_rdata = ram_rdata;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: RAM image, round-robin pointer, pending responses.
  typedef struct {
    int                due;
    int                owner;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  resp_t             q[$];
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_ptr = 0;
  bit                mon_en = 1'b0;

  task automatic issue(input logic [NREQ-1:0] v, input logic [NREQ*ADDR_W-1:0] a,
                       input logic [NREQ-1:0] wm, input logic [NREQ*DATA_W-1:0] wd);
    int              order[$];
    int              g;
    int              addr;
    logic [NREQ-1:0] exp_ready;
    logic            exp_en;
    resp_t           e;
    @(posedge clock); #1;
    req_valid = v;
    req_addr  = a;
    req_wmode = wm;
    req_wdata = wd;
    for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
    g = -1;
    foreach (order[j]) if (g < 0 && v[order[j]]) g = order[j];
    exp_ready = '0;
    exp_en    = 1'b0;
    if (g >= 0) begin
      addr    = int'(a[g*ADDR_W +: ADDR_W]);
      e.due   = cyc + 1;
      e.owner = g;
      e.err   = addr >= DEPTH;
      e.rdata = (!e.err && !wm[g]) ? m_mem[addr] : '0;
      if (!e.err && wm[g]) m_mem[addr] = wd[g*DATA_W +: DATA_W];
      exp_en       = !e.err;
      exp_ready[g] = 1'b1;
      m_ptr        = (g + 1) % NREQ;
      q.push_back(e);
    end
    @(negedge clock);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("RW0_en", 64'(RW0_en), 64'(exp_en));
  endtask

  task automatic reset_and_init();
    @(posedge clock); #1;
    reset     = 1'b1;
    req_valid = '1;
    q.delete();
    @(posedge clock); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    m_ptr  = 0;
    foreach (m_mem[i]) m_mem[i] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clock);
      check("init_done_low", 64'(init_done), 64'(0));
      check("init_ready", 64'(req_ready), 64'(0));
      check("init_en", 64'(RW0_en), 64'(1));
      check("init_wmode", 64'(RW0_wmode), 64'(1));
      check("init_wdata", RW0_wdata, 64'(0));
      check("init_addr", 64'(RW0_addr), 64'(k));
      @(posedge clock); #1;
    end
    req_valid = '0;
    @(negedge clock);
    check("init_done_high", 64'(init_done), 64'(1));
    check("idle_en", 64'(RW0_en), 64'(0));
  endtask

  // Monitor: compares every cycle's response outputs against the scoreboard head.
  logic [NREQ-1:0]   exp_v;
  logic [NREQ-1:0]   exp_e;
  logic [DATA_W-1:0] exp_d;
  resp_t             m_e;
  always @(negedge clock) begin
    if (mon_en) begin
      exp_v = '0;
      exp_e = '0;
      exp_d = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_e = q.pop_front();
        exp_v[m_e.owner] = 1'b1;
        exp_e[m_e.owner] = m_e.err;
        exp_d            = m_e.rdata;
      end
      check("resp_valid", 64'(resp_valid), 64'(exp_v));
      if (exp_v != '0) begin
        check("resp_err", 64'(resp_err), 64'(exp_e));
        check("resp_rdata", resp_rdata, exp_d);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ*ADDR_W-1:0] a;
    logic [NREQ*DATA_W-1:0] wd;
    logic [ADDR_W-1:0]      one_addr;

    reset_and_init();

    // Both requesters contend: grants alternate 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) issue(2'b11, {6'd2, 6'd1}, 2'b00, '0);

    // Write then read back one location through requester 0.
    issue(2'b01, {6'd0, 6'd5}, 2'b01, {64'd0, 64'hDEADBEEF_00000001});
    issue(2'b01, {6'd0, 6'd5}, 2'b00, '0);

    // Out-of-range read from requester 1, then the last valid address.
    issue(2'b10, {6'd50, 6'd0}, 2'b00, '0);
    issue(2'b10, {6'd63, 6'd0}, 2'b01, '1);
    issue(2'b01, {6'd0, 6'd47}, 2'b00, '0);
    issue(2'b10, {6'd47, 6'd0}, 2'b00, '0);

    // Randomized traffic over a small hot address set plus some out-of-range hits.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        case ($urandom_range(0, 3))
          0:       one_addr = ADDR_W'($urandom_range(DEPTH, 63));
          1:       one_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
          default: one_addr = ADDR_W'($urandom_range(0, 7));
        endcase
        a[r*ADDR_W +: ADDR_W]  = one_addr;
        wd[r*DATA_W +: DATA_W] = {$urandom, $urandom};
      end
      issue(NREQ'($urandom), a, NREQ'($urandom), wd);
    end
    issue('0, '0, '0, '0);

    // Reset right after an accepted read drops its response and re-zeroes the RAM.
    issue(2'b01, {6'd0, 6'd5}, 2'b01, {64'd0, 64'd1});
    issue(2'b01, {6'd0, 6'd5}, 2'b00, '0);
    reset_and_init();
    issue(2'b01, {6'd0, 6'd5}, 2'b00, '0);
    issue('0, '0, '0, '0);
    issue('0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
